// File: rtl/arb_pkg.sv
// Shared defaults and types for the two-client request queue and its arbiter.
package arb_pkg;

  localparam int DEPTH = 4;
  localparam int DW    = 8;

  typedef logic       client_idx_t;
  typedef logic [1:0] req_vec_t;

endpackage

// File: rtl/arb_fifo.sv
// One client queue: storage, wrapping pointers, occupancy count, full/empty and sticky overflow.
module arb_fifo
  import arb_pkg::*;
#(
  parameter int FDEPTH = DEPTH,
  parameter int FDW    = DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [FDW-1:0]           data,
  input  logic                     pop,
  output logic [FDW-1:0]           head,
  output logic [$clog2(FDEPTH):0]  count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);

  localparam int AW = $clog2(FDEPTH);
  localparam int CW = AW + 1;

  logic [FDW-1:0] mem_q [FDEPTH];
  logic [FDW-1:0] mem_d [FDEPTH];
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           full_s, empty_s, push_ok_s, pop_ok_s;

  assign full_s    = (count_q == CW'(FDEPTH));
  assign empty_s   = (count_q == '0);
  // A full queue drops the push even if a pop frees a slot at the same edge.
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty_s;

  // Next-state for storage, pointers, count and overflow.
  always_comb begin
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_ok_s) begin
      mem_d[wptr_q] = data;
      wptr_d        = wptr_q + AW'(1);
    end else begin
      ovf_d = ovf_q | push;
    end
    if (pop_ok_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FDEPTH; i++) mem_q[i] <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;
  assign full  = full_s;
  assign empty = empty_s;
  assign ovf   = ovf_q;

endmodule

// File: rtl/arb_req_queue.sv
// Two per-client request queues feeding an external arbiter; dequeues on grant into an output register.
// Optional feature macro: ARB_REQ_QUEUE_STATS_EN adds saturating per-client pop counters.
module arb_req_queue
  import arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push0,
  input  logic [DW-1:0]   data0,
  input  logic            push1,
  input  logic [DW-1:0]   data1,
  output logic            full0,
  output logic            full1,
  output req_vec_t        request,
  input  req_vec_t        grant,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output client_idx_t     out_src,
`ifdef ARB_REQ_QUEUE_STATS_EN
  output logic [15:0]     pop_cnt0,
  output logic [15:0]     pop_cnt1,
`endif
  output logic [1:0]      ovf
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW-1:0] head0_s, head1_s;
  logic [CW-1:0] count0_s, count1_s;
  logic          empty0_s, empty1_s, ovf0_s, ovf1_s;
  logic          pop0_s, pop1_s;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  client_idx_t   out_src_q, out_src_d;

  arb_fifo #(.FDEPTH(DEPTH), .FDW(DW)) u_fifo0 (
    .clk(clk), .rst(rst), .push(push0), .data(data0), .pop(pop0_s),
    .head(head0_s), .count(count0_s), .full(full0), .empty(empty0_s), .ovf(ovf0_s)
  );

  arb_fifo #(.FDEPTH(DEPTH), .FDW(DW)) u_fifo1 (
    .clk(clk), .rst(rst), .push(push1), .data(data1), .pop(pop1_s),
    .head(head1_s), .count(count1_s), .full(full1), .empty(empty1_s), .ovf(ovf1_s)
  );

  // Grant of 2'b11 favours client 1; a grant on an empty queue is stale and ignored.
  always_comb begin
    pop0_s = 1'b0;
    pop1_s = 1'b0;
    if (grant[1]) begin
      pop1_s = !empty1_s;
    end else if (grant[0]) begin
      pop0_s = !empty0_s;
    end else begin
      pop0_s = 1'b0;
      pop1_s = 1'b0;
    end
  end

  // Output register next-state: data and source hold when nothing is popped.
  always_comb begin
    out_valid_d = pop0_s | pop1_s;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (pop1_s) begin
      out_data_d = head1_s;
      out_src_d  = 1'b1;
    end else if (pop0_s) begin
      out_data_d = head0_s;
      out_src_d  = 1'b0;
    end else begin
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign request   = {(count1_s != '0), (count0_s != '0)};
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign ovf       = {ovf1_s, ovf0_s};

`ifdef ARB_REQ_QUEUE_STATS_EN
  logic [15:0] pop_cnt0_q, pop_cnt0_d, pop_cnt1_q, pop_cnt1_d;

  // Saturating accepted-pop counters.
  always_comb begin
    pop_cnt0_d = pop_cnt0_q;
    pop_cnt1_d = pop_cnt1_q;
    if (pop0_s && (pop_cnt0_q != 16'hFFFF)) begin
      pop_cnt0_d = pop_cnt0_q + 16'd1;
    end else begin
      pop_cnt0_d = pop_cnt0_q;
    end
    if (pop1_s && (pop_cnt1_q != 16'hFFFF)) begin
      pop_cnt1_d = pop_cnt1_q + 16'd1;
    end else begin
      pop_cnt1_d = pop_cnt1_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt0_q <= 16'd0;
      pop_cnt1_q <= 16'd0;
    end else begin
      pop_cnt0_q <= pop_cnt0_d;
      pop_cnt1_q <= pop_cnt1_d;
    end
  end

  assign pop_cnt0 = pop_cnt0_q;
  assign pop_cnt1 = pop_cnt1_q;
`endif

endmodule

// File: doc/arb_req_queue.md
ARB_REQ_QUEUE -- requirements
Module: arb_req_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 DEPTH, 4, SHALL be the entries per client queue (power of two, 2..16).
REQ-003 DW, 8, SHALL be the payload width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on posedge.
REQ-005 rst  in  1  SHALL be the synchronous active-high reset.
REQ-006 push0 / push1  in  1  SHALL be the client 0 / client 1 enqueue strobes.
REQ-007 data0 / data1  in  DW  SHALL be the client 0 / client 1 payloads, sampled with push.
REQ-008 full0 / full1  out  1  SHALL mean the queue holds DEPTH entries.
REQ-009 request  out  2  SHALL be the per-client request to the downstream arbiter: bit i = queue i non-empty.
REQ-010 grant  in  2  SHALL be the registered grant from the arbiter; bit i = client i granted.
REQ-011 out_valid  out  1  SHALL be a one-cycle strobe marking a dequeued entry.
REQ-012 out_data / out_src  out  DW / 1  SHALL carry the dequeued payload and its client index.
REQ-013 ovf  out  2  SHALL be per-client sticky overflow flags.

Function
REQ-014 Each queue SHALL be a FIFO with read pointer, write pointer and a count of width log2(DEPTH)+1; pointers SHALL wrap modulo DEPTH.
REQ-015 request[i] SHALL be driven combinationally from the registered count (count_i != 0), with zero added latency.
REQ-016 A push with count < DEPTH SHALL write the payload at the write pointer and increment the count at the same edge.
REQ-017 A push with count == DEPTH SHALL be dropped and SHALL set ovf[i], even when a pop happens in the same cycle.
REQ-018 A grant[i]=1 at an edge with count_i != 0 SHALL pop the head; out_data, out_src=i and out_valid=1 SHALL be registered at that edge (1-cycle latency).
REQ-019 A grant[i]=1 with count_i == 0 (stale grant, caused by the arbiter's registered grant lagging request by one cycle) SHALL be ignored: no pop, no underflow, out_valid=0.
REQ-020 grant == 2'b11 SHALL be treated as grant[1] only; grant == 2'b00 SHALL pop nothing.
REQ-021 A simultaneous push and pop on the same non-full queue SHALL leave the count unchanged and both SHALL take effect.
REQ-022 A push to an empty queue in the same cycle as a stale grant SHALL be accepted; the grant SHALL be ignored.
REQ-023 out_valid SHALL be 0 in every cycle following an edge with no pop; out_data and out_src SHALL hold their last values.
REQ-024 ovf[i] SHALL clear only on rst.

Reset
REQ-025 With rst high at an edge, all counts and pointers SHALL become 0, and request, out_valid, out_data, out_src and ovf SHALL become 0; full0 and full1 SHALL read 0.
REQ-026 A reset asserted mid-stream SHALL discard all queued entries; pushes and grants sampled at the reset edge SHALL be ignored.

Configuration
REQ-027 ARB_REQ_QUEUE_STATS_EN SHALL, when defined, add outputs pop_cnt0 and pop_cnt1 (16-bit each), saturating at 16'hFFFF, incremented per accepted pop and cleared by rst.
REQ-028 Without ARB_REQ_QUEUE_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package arb_pkg SHALL hold the DEPTH and DW defaults, the client-index typedef, and the 2-bit request/grant vector typedef shared with the arbiter.
REQ-030 A sub-module arb_fifo (one client queue: storage, pointers, count, full/empty, ovf) SHALL be instantiated twice; pop selection and the output register SHALL live in arb_req_queue.

Verification
REQ-031 Reset, then push0 of 8'hA5 -> request=2'b01 in the next cycle; grant=2'b01 -> out_valid=1, out_data=8'hA5, out_src=0 one cycle later; request=2'b00.
REQ-032 Both queues hold 2 entries, grant=2'b10 for 2 cycles then 2'b01 -> client-1 entries come out in push order, then client-0 entries; no entry is lost.
REQ-033 Push 5 entries into client 0 (DEPTH=4) -> full0=1 after the 4th push, 5th push dropped, ovf=2'b01; the 4 dequeued values match the first 4 pushed.
REQ-034 A single entry is popped while grant stays 2'b01 for one more cycle -> the stale grant causes no pop, out_valid=0, count stays 0.
REQ-035 Full queue with push and grant in the same cycle -> push dropped, ovf set, count=3.
REQ-036 rst asserted with 3 entries queued -> count=0, request=2'b00 next cycle; with ARB_REQ_QUEUE_STATS_EN, pop_cnt0=0.
